// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register file with optional wait states.
// Define APB_SLV_ERR_EN to report out-of-range and misaligned accesses on pslverr.
module apb_slave_mem #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              psel,
    input  logic              penable,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup;
    logic              go_access;
    logic [ADDR_W-1:0] xfer_addr;
    logic              xfer_write;
    logic [ADDR_W-1:0] xfer_offset;
    logic [IDX_W-1:0]  xfer_idx;
    logic              xfer_err;
    logic [ADDR_W-1:0] acc_offset;
    logic [IDX_W-1:0]  acc_idx;
    logic              mem_we;

    assign setup = (state_reg == ST_IDLE) && psel && !penable;

    // With no wait states the response is registered on the setup edge itself,
    // so the live bus is decoded in IDLE and the latched copy afterwards.
    assign go_access = (setup && (WAIT_CYCLES == 0)) ||
                       ((state_reg == ST_WAIT) && psel && penable && (cnt_reg <= 4'd1));

    assign xfer_addr   = (state_reg == ST_IDLE) ? paddr  : addr_reg;
    assign xfer_write  = (state_reg == ST_IDLE) ? pwrite : write_reg;
    assign xfer_offset = xfer_addr - BASE_ADDR;
    assign xfer_idx    = IDX_W'(xfer_offset >> 2);

    always_comb begin
`ifdef APB_SLV_ERR_EN
        xfer_err = (xfer_addr < BASE_ADDR) ||
                   ((xfer_offset >> 2) >= ADDR_W'(DEPTH)) ||
                   (xfer_addr[1:0] != 2'b00);
`else
        xfer_err = 1'b0;
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (setup) begin
                    state_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_next = ST_IDLE;
                end else if (go_access) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            prdata    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (setup) begin
                addr_reg  <= paddr;
                write_reg <= pwrite;
                wdata_reg <= pwdata;
                cnt_reg   <= 4'(WAIT_CYCLES);
            end else if ((state_reg == ST_WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            pready  <= go_access;
            pslverr <= go_access && xfer_err;
            if (go_access && !xfer_write && !xfer_err) begin
                prdata <= mem[xfer_idx];
            end else begin
                prdata <= '0;
            end
        end
    end

    // pslverr is only ever high during ACCESS, so it doubles as the write veto.
    assign acc_offset = addr_reg - BASE_ADDR;
    assign acc_idx    = IDX_W'(acc_offset >> 2);
    assign mem_we     = (state_reg == ST_ACCESS) && write_reg && !pslverr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[acc_idx] <= wdata_reg;
        end
    end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB3 completer (slave) backed by a word-addressed register file, forming the responder end of the APB interface that the master agent drives. It decodes setup/access phases, inserts a parameterised number of wait states, and returns read data or commits writes. With the error feature compiled in, it also flags out-of-range and misaligned accesses. It is the reference DUT for the APB UVC and its protocol assertions.

## Interface
- ADDR_W, 32, paddr width
- DATA_W, 32, pwdata/prdata width
- DEPTH, 256, number of DATA_W words in the register file (power of two)
- BASE_ADDR, 32'h0, byte address of word 0
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15)

- clk  input  1  rising-edge clock
- resetn  input  1  reset; asynchronous, active-low
- psel  input  1  slave select
- penable  input  1  access-phase strobe
- paddr  input  ADDR_W  byte address
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  DATA_W  write data
- prdata  output  DATA_W  read data, valid when pready=1 and read
- pready  output  1  transfer completes this cycle
- pslverr  output  1  error response, valid only when pready=1

## Operation
- Reset: state IDLE; prdata=0, pready=0, pslverr=0; wait counter=0; all memory words cleared to 0.
- Setup detection: psel=1 and penable=0 while in IDLE.
- On setup, latch paddr, pwrite and pwdata, and load the counter with WAIT_CYCLES.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE -> ACCESS on setup when WAIT_CYCLES=0.
  - IDLE -> WAIT on setup when WAIT_CYCLES>0.
  - WAIT: decrement the counter each cycle; -> ACCESS when the counter reaches 1 with psel=1 and penable=1.
  - WAIT -> IDLE on psel=0 (master abort). No write occurs and no response is given.
  - ACCESS: pready=1 for exactly one cycle, then -> IDLE unconditionally.
- Index = (latched paddr - BASE_ADDR) >> 2. Subtraction is ADDR_W-bit unsigned.
- Write commits on the ACCESS cycle edge. Reads drive prdata from mem[index] in ACCESS.
- Outside ACCESS: prdata=0, pslverr=0, pready=0.
- pwdata, paddr and pwrite changes after setup are ignored; the latched values are used.
- Write followed by a read of the same word returns the new value; there is no read-after-write hazard.
- Reset mid-transfer returns to IDLE immediately with all outputs 0. A pending write is discarded.

## Timing
- Setup at cycle T gives pready=1 at cycle T+1+WAIT_CYCLES.
- pready is 0 during the setup cycle and rises together with penable, satisfying the setup/access sequence checks.
- pready, prdata and pslverr are registered outputs; there is no combinational input-to-output path.
- Back-to-back: a new setup in the cycle after ACCESS is accepted, giving 2+WAIT_CYCLES cycles per transfer.
- psel=1 with penable=1 in IDLE (missing setup) is ignored; no response is given.

## Configuration
- APB_SLV_ERR_EN defined:
  - pslverr=1 in ACCESS when paddr < BASE_ADDR, index >= DEPTH, or paddr[1:0] != 0.
  - An errored write leaves memory unchanged; an errored read returns prdata=0.
- APB_SLV_ERR_EN undefined:
  - pslverr is tied to 0.
  - Index wraps modulo DEPTH, paddr[1:0] is ignored, and all accesses complete normally.

## Test plan
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 at T -> pready=1 at T+1, pslverr=0. Read of 0x10 -> prdata=0xDEADBEEF at pready.
- WAIT_CYCLES=3: read 0x0 after reset -> pready low for cycles T..T+3, high only at T+4; prdata=0.
- APB_SLV_ERR_EN defined, DEPTH=256: write 0x1234 to 0x400 -> pslverr=1 with pready. Read of 0x400 -> prdata=0, pslverr=1. Write to 0x11 -> pslverr=1 and memory unchanged.
- Error feature off, DEPTH=256: write 0xA5A5A5A5 to 0x400 -> pslverr=0. Read of 0x0 returns 0xA5A5A5A5 (wrap).
- Back-to-back write 0x20 = 1 then read 0x20 with no idle cycle -> second pready 2 cycles after the first; prdata=1.
- Reset mid-transfer: WAIT_CYCLES=5, resetn=0 during WAIT of a write to 0x8 -> outputs 0 at once. A later read of 0x8 returns 0.
